alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
Shares one combinational 6-bit ALU datapath between two requesters using round-robin arbitration and valid/ready handshakes. An accepted operation is computed in the same cycle and registered into a single-entry response buffer. The response carries the requester ID and the out/carry/zero flags. The block sits between the pin-level wrapper (or two internal masters) and the ALU core.

Parameters:
WIDTH, 6, operand/result width in bits (min 2)
SHW, $clog2(WIDTH), number of shift-amount bits taken from b

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_ctrl  input  4  requester 0 opcode
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid / req1_ready / req1_ctrl / req1_a / req1_b  same as requester 0, for requester 1
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer takes the response this cycle
rsp_id  output  1  requester that issued the operation
rsp_out  output  WIDTH  ALU result
rsp_carry  output  1  carry (ADD) / borrow (SUB), else 0
rsp_zero  output  1  rsp_out == 0
rsp_illegal  output  1  opcode not in the defined set

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_illegal go to 0 and rsp_zero goes to 1. The round-robin pointer (last_grant) goes to 1, so requester 0 wins first. Reset during a held response discards that response.
- Opcodes: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000. Any other code gives out=0, carry=0, rsp_illegal=1.
- Arithmetic:
  - ADD: {carry,out} = a+b, computed in WIDTH+1 bits.
  - SUB: {carry,out} = {1'b0,a} - {1'b0,b}; carry=1 means borrow.
  - Shifts use sh = b[SHW-1:0]. If sh >= WIDTH, SLL/SRL give 0 and SRA gives all copies of a[WIDTH-1].
  - SLT: out = 1 when signed(a) < signed(b), else 0.
  - Carry is 0 for every opcode except ADD and SUB. rsp_zero is computed from the registered out.
- can_accept = !rsp_valid || rsp_ready. A pass-through slot gives full throughput of 1 op/cycle.
- Grant, combinational:
  - Only one reqN_valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = grant==N && reqN_valid && can_accept. At most one ready per cycle.
- On accept, the buffer loads the ALU result, rsp_id=N and rsp_valid=1 on the next edge (latency 1 cycle), and last_grant updates to N. last_grant does not move on cycles with no accept.
- Hold: while rsp_valid && !rsp_ready, all rsp_* outputs stay stable and both reqN_ready=0.
- Drain and refill: if rsp_ready=1 and a new accept happen in the same cycle, the buffer reloads and rsp_valid stays 1. If rsp_ready=1 with no accept, rsp_valid goes to 0.
- Requester inputs are sampled only in the accept cycle. A requester may drop valid without being accepted; no ordering is required.
- A requester left waiting gets the grant within 2 accepts (starvation bound).

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams (AND..SLT) as a 4-bit typedef alu_op_t;
  - a response struct {id, out, carry, zero, illegal}.
- Sub-module alu_core: purely combinational, ports ctrl, a, b -> out, carry, illegal, parameterised by WIDTH. The arbiter instantiates it once, behind a 2:1 operand mux.
- The arbiter contains the grant logic, last_grant flop and response register.

Test Plan:
- Reset then req0 ADD a=6'h3F b=6'h01, rsp_ready=1 -> next cycle rsp_valid=1, id=0, out=6'h00, carry=1, zero=1.
- Both requesters valid continuously, rsp_ready=1, req0 SUB 5-7, req1 SLT a=6'h20 b=6'h01:
  - grants alternate 0,1,0,1 starting with 0;
  - id0 responses: out=6'h3E, carry=1;
  - id1 responses: out=6'h01.
- Backpressure: accept req1 SRA a=6'h30 b=2, then hold rsp_ready=0 for 5 cycles -> out=6'h3C held stable, both ready=0. Release -> same-cycle refill, no bubble.
- Shift bound: SLL a=6'h01 b=7, then SRA a=6'h20 b=6 -> out=6'h00, then out=6'h3F.
- Illegal op 4'b1111 a=6'h15 -> out=0, zero=1, carry=0, illegal=1.
- Assert rst for one cycle while a response is held -> rsp_valid=0, zero=1 next cycle. When both are valid, the first grant after reset goes to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU arbiter.
//   alu_op_t     : 4-bit opcode plus the named opcode constants
//   alu_rsp_t    : response record {id, out, carry, zero, illegal} at the default width
package alu_pkg;

  localparam int unsigned DefWidth = 6;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OpAnd = 4'b0000;
  localparam alu_op_t OpOr  = 4'b0001;
  localparam alu_op_t OpAdd = 4'b0010;
  localparam alu_op_t OpSll = 4'b0011;
  localparam alu_op_t OpXor = 4'b0100;
  localparam alu_op_t OpSrl = 4'b0101;
  localparam alu_op_t OpSub = 4'b0110;
  localparam alu_op_t OpSra = 4'b0111;
  localparam alu_op_t OpSlt = 4'b1000;

  typedef struct packed {
    logic                id;
    logic [DefWidth-1:0] out;
    logic                carry;
    logic                zero;
    logic                illegal;
  } alu_rsp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
//   ctrl    : opcode (alu_op_t)
//   a, b    : operands; shifts use b[SHW-1:0] as the amount
//   out     : result
//   carry   : carry for ADD, borrow for SUB, 0 otherwise
//   illegal : opcode outside the defined set (out and carry forced to 0)
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  alu_op_t          ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             illegal
);

  logic [SHW-1:0] sh;
  logic           sh_over;
  logic [WIDTH:0] ext;

  assign sh = b[SHW-1:0];
  // Amounts at or beyond WIDTH are only reachable when WIDTH is not a power of two.
  assign sh_over = (32'(sh) >= WIDTH);

  always_comb begin
    out     = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    ext     = '0;
    case (ctrl)
      OpAnd: out = a & b;
      OpOr:  out = a | b;
      OpXor: out = a ^ b;
      OpAdd: begin
        ext   = {1'b0, a} + {1'b0, b};
        out   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OpSub: begin
        ext   = {1'b0, a} - {1'b0, b};
        out   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OpSll: out = sh_over ? '0 : (a << sh);
      OpSrl: out = sh_over ? '0 : (a >> sh);
      OpSra: out = sh_over ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      OpSlt: out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a single-entry
// registered response buffer that refills in the same cycle it drains.
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/ready/ctrl/a/b      : requester N operation handshake (N = 0, 1)
//   rsp_valid/ready                : response handshake
//   rsp_id/out/carry/zero/illegal  : response payload
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  logic             can_accept;
  logic             grant;
  logic             accept;
  alu_op_t          op_ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry, alu_illegal;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = req0_valid && !grant && can_accept;
  assign req1_ready = req1_valid && grant && can_accept;
  assign accept     = req0_ready || req1_ready;

  assign op_ctrl = grant ? req1_ctrl : req0_ctrl;
  assign op_a    = grant ? req1_a    : req0_a;
  assign op_b    = grant ? req1_b    : req0_b;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_alu_core (
    .ctrl    (op_ctrl),
    .a       (op_a),
    .b       (op_b),
    .out     (alu_out),
    .carry   (alu_carry),
    .illegal (alu_illegal)
  );

  always_comb begin
    last_grant_d  = last_grant_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_out_d     = rsp_out_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_illegal_d = rsp_illegal_q;
    if (accept) begin
      last_grant_d  = grant;
      rsp_valid_d   = 1'b1;
      rsp_id_d      = grant;
      rsp_out_d     = alu_out;
      rsp_carry_d   = alu_carry;
      rsp_illegal_d = alu_illegal;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_out_q     <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_out_q     <= rsp_out_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_out     = rsp_out_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_illegal = rsp_illegal_q;
  // Zero flag derived from the registered result, so it reads 1 out of reset.
  assign rsp_zero    = (rsp_out_q == '0);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios followed by random
// traffic, all compared against an integer-arithmetic reference model.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_illegal;
  logic [W-1:0] rsp_out;

  int checks   = 0;
  int failures = 0;

  // Reference state: buffer occupancy, last winner, held response.
  logic     m_valid = 1'b0;
  logic     m_last  = 1'b1;
  alu_rsp_t m_rsp   = '0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_ctrl   (req0_ctrl),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_ctrl   (req1_ctrl),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_out     (rsp_out),
    .rsp_carry   (rsp_carry),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic on 6-bit values.
  function automatic alu_rsp_t model_alu(input int op, input int a, input int b, input logic id);
    alu_rsp_t r;
    int sa, sb, sh, res, c;
    sa  = (a >= 32) ? a - 64 : a;
    sb  = (b >= 32) ? b - 64 : b;
    sh  = b % 8;
    res = 0;
    c   = 0;
    r   = '0;
    case (op)
      0: res = a & b;
      1: res = a | b;
      2: begin res = a + b; c = (res > 63) ? 1 : 0; res = res % 64; end
      3: res = (sh >= 6) ? 0 : (a * (1 << sh)) % 64;
      4: res = a ^ b;
      5: res = (sh >= 6) ? 0 : a / (1 << sh);
      6: begin res = a - b; c = (res < 0) ? 1 : 0; res = (res + 64) % 64; end
      7: res = (sa >>> sh) & 63;
      8: res = (sa < sb) ? 1 : 0;
      default: r.illegal = 1'b1;
    endcase
    r.id    = id;
    r.out   = 6'(res);
    r.carry = (c != 0);
    r.zero  = (res == 0);
    return r;
  endfunction

  // One clock: check readies mid-cycle, advance the model, check the buffer after the edge.
  task automatic step();
    logic     can, g, r0, r1;
    alu_rsp_t nxt;
    @(negedge clk);
    can = !m_valid || rsp_ready;
    if (req0_valid && req1_valid) g = !m_last;
    else                          g = req1_valid;
    r0 = req0_valid && can && !g;
    r1 = req1_valid && can && g;
    check_eq("req0_ready", req0_ready, r0);
    check_eq("req1_ready", req1_ready, r1);
    if (g) nxt = model_alu(int'(req1_ctrl), int'(req1_a), int'(req1_b), 1'b1);
    else   nxt = model_alu(int'(req0_ctrl), int'(req0_a), int'(req0_b), 1'b0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid    = 1'b0;
      m_last     = 1'b1;
      m_rsp      = '0;
      m_rsp.zero = 1'b1;
    end else if (r0 || r1) begin
      m_rsp   = nxt;
      m_valid = 1'b1;
      m_last  = g;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    check_eq("rsp_valid", rsp_valid, m_valid);
    check_eq("rsp_id", rsp_id, m_rsp.id);
    check_eq("rsp_out", rsp_out, m_rsp.out);
    check_eq("rsp_carry", rsp_carry, m_rsp.carry);
    check_eq("rsp_zero", rsp_zero, m_rsp.zero);
    check_eq("rsp_illegal", rsp_illegal, m_rsp.illegal);
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      req0_valid = v; req0_ctrl = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctrl = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'h0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    m_rsp.zero = 1'b1;
    check_eq("reset_valid", rsp_valid, 0);
    check_eq("reset_zero", rsp_zero, 1);
    check_eq("reset_out", rsp_out, 0);
    rst = 1'b0;

    // ADD overflow to zero.
    set_req(0, 1'b1, OpAdd, 6'h3F, 6'h01);
    step();
    check_eq("add_valid", rsp_valid, 1);
    check_eq("add_id", rsp_id, 0);
    check_eq("add_out", rsp_out, 6'h00);
    check_eq("add_carry", rsp_carry, 1);
    check_eq("add_zero", rsp_zero, 1);
    set_req(0, 1'b0, OpAdd, 6'h00, 6'h00);
    step();

    // Alternation under contention, starting with requester 0 after reset.
    do_reset();
    set_req(0, 1'b1, OpSub, 6'd5, 6'd7);
    set_req(1, 1'b1, OpSlt, 6'h20, 6'h01);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("alt_id", rsp_id, i % 2);
      check_eq("alt_out", rsp_out, (i % 2 == 0) ? 6'h3E : 6'h01);
      check_eq("alt_carry", rsp_carry, (i % 2 == 0) ? 1 : 0);
    end

    // Backpressure hold then same-cycle refill. Last winner is 1, so idle 0 for one op.
    set_req(0, 1'b0, OpAnd, 6'h00, 6'h00);
    set_req(1, 1'b1, OpSra, 6'h30, 6'd2);
    step();
    check_eq("sra_id", rsp_id, 1);
    check_eq("sra_out", rsp_out, 6'h3C);
    set_req(0, 1'b1, OpXor, 6'h0F, 6'h33);
    set_req(1, 1'b1, OpOr, 6'h01, 6'h02);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_out", rsp_out, 6'h3C);
      check_eq("hold_r0", req0_ready, 0);
      check_eq("hold_r1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("refill_valid", rsp_valid, 1);
    check_eq("refill_id", rsp_id, 0);
    check_eq("refill_out", rsp_out, 6'h3C);
    set_req(1, 1'b0, OpOr, 6'h00, 6'h00);

    // Shift amounts beyond the width.
    set_req(0, 1'b1, OpSll, 6'h01, 6'd7);
    step();
    check_eq("sll_over", rsp_out, 6'h00);
    set_req(0, 1'b1, OpSra, 6'h20, 6'd6);
    step();
    check_eq("sra_over", rsp_out, 6'h3F);

    // Illegal opcode.
    set_req(0, 1'b1, 4'b1111, 6'h15, 6'h00);
    step();
    check_eq("ill_out", rsp_out, 0);
    check_eq("ill_zero", rsp_zero, 1);
    check_eq("ill_carry", rsp_carry, 0);
    check_eq("ill_flag", rsp_illegal, 1);

    // Reset discards a held response; first contended grant afterwards goes to 0.
    set_req(0, 1'b1, OpAdd, 6'h02, 6'h03);
    rsp_ready = 1'b0;
    step();
    check_eq("pre_rst_valid", rsp_valid, 1);
    do_reset();
    check_eq("post_rst_valid", rsp_valid, 0);
    check_eq("post_rst_zero", rsp_zero, 1);
    rsp_ready = 1'b1;
    set_req(1, 1'b1, OpAnd, 6'h3F, 6'h3F);
    step();
    check_eq("post_rst_id", rsp_id, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_req(0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              6'($urandom), 6'($urandom));
      set_req(1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              6'($urandom), 6'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
